// File: rtl/fft_frame_arbiter.sv
// Frame-granular round-robin sharing of one FFT pipeline between two sample sources,
// with channel / start-of-frame relabelling of the FFT output stream.
module fft_frame_arbiter #(
    parameter int WIDTH = 16,
    parameter int N     = 64,
    parameter int TAGQ  = 4,
    parameter int GAP   = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              req,
    output logic [1:0]              src_rd,
    input  logic signed [WIDTH-1:0] src0_r,
    input  logic signed [WIDTH-1:0] src0_i,
    input  logic signed [WIDTH-1:0] src1_r,
    input  logic signed [WIDTH-1:0] src1_i,
    output logic                    fft_idata_en,
    output logic signed [WIDTH-1:0] fft_idata_r,
    output logic signed [WIDTH-1:0] fft_idata_i,
    input  logic                    fft_odata_en,
    input  logic signed [WIDTH-1:0] fft_odata_r,
    input  logic signed [WIDTH-1:0] fft_odata_i,
    output logic                    odata_en,
    output logic signed [WIDTH-1:0] odata_r,
    output logic signed [WIDTH-1:0] odata_i,
    output logic                    odata_ch,
    output logic                    odata_sof,
    output logic                    busy,
    output logic                    err
);
    localparam int IW = $clog2(N);
    localparam int QW = $clog2(TAGQ);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, HOLD} state_t;

    state_t          state, state_nxt;
    logic            ch, last_ch;
    logic [IW-1:0]   icnt;
    logic [GW-1:0]   gcnt;
    logic            push, pop, arb_ok, arb_ch, frame_end, hold_end, tag_empty;
    logic            tag_mem [TAGQ];
    logic [QW-1:0]   wptr, rptr;
    logic [QW:0]     tcnt;
    logic [IW-1:0]   ocnt;

    logic                    in_vld_p1, out_vld_p1, out_ch_p1, out_sof_p1;
    logic signed [WIDTH-1:0] in_r_p1, in_i_p1, out_r_p1, out_i_p1;

    // On simultaneous requests serve the channel that did not win last time.
    function automatic logic rr_pick(input logic [1:0] r, input logic last);
        if (r == 2'b11) return ~last;
        return r[1];
    endfunction

    assign arb_ok    = (tcnt < (QW+1)'(TAGQ)) && (req != 2'b00);
    assign arb_ch    = rr_pick(req, last_ch);
    assign frame_end = (icnt == IW'(N-1));
    assign hold_end  = (gcnt == GW'(GAP-1));
    assign tag_empty = (tcnt == '0);
    assign pop       = fft_odata_en && (ocnt == IW'(N-1)) && !tag_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (arb_ok) begin
                    state_nxt = STREAM;
                    push      = 1'b1;
                end
            end
            STREAM: begin
                if (frame_end) begin
                    if (GAP > 0)     state_nxt = HOLD;
                    else if (arb_ok) push      = 1'b1;
                    else             state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (hold_end) begin
                    if (arb_ok) begin
                        state_nxt = STREAM;
                        push      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src_rd = 2'b00;
        if (state == STREAM) src_rd = ch ? 2'b10 : 2'b01;
        busy = (state == STREAM) || !tag_empty;
    end

    // last_ch resets to 1 so the first contested grant goes to ch0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch      <= 1'b0;
            last_ch <= 1'b1;
            icnt    <= '0;
            gcnt    <= '0;
        end else begin
            if (push) begin
                ch      <= arb_ch;
                last_ch <= arb_ch;
            end
            icnt <= (state == STREAM && !frame_end) ? icnt + 1'b1 : '0;
            gcnt <= (state == HOLD) ? gcnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) tag_mem[wptr] <= arb_ch;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            tcnt <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      tcnt <= tcnt + 1'b1;
            else if (pop && !push) tcnt <= tcnt - 1'b1;
        end
    end

    // Stage p1: registered FFT input stream
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_vld_p1 <= 1'b0;
            in_r_p1   <= '0;
            in_i_p1   <= '0;
        end else begin
            in_vld_p1 <= |src_rd;
            in_r_p1   <= ch ? src1_r : src0_r;
            in_i_p1   <= ch ? src1_i : src0_i;
        end
    end

    // Stage p1: tagged result stream; an untagged result is forwarded as ch0 and flagged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_vld_p1 <= 1'b0;
            out_r_p1   <= '0;
            out_i_p1   <= '0;
            out_ch_p1  <= 1'b0;
            out_sof_p1 <= 1'b0;
            ocnt       <= '0;
            err        <= 1'b0;
        end else begin
            out_vld_p1 <= fft_odata_en;
            out_sof_p1 <= fft_odata_en && (ocnt == '0);
            if (fft_odata_en) begin
                out_r_p1  <= fft_odata_r;
                out_i_p1  <= fft_odata_i;
                out_ch_p1 <= tag_empty ? 1'b0 : tag_mem[rptr];
                ocnt      <= ocnt + 1'b1;
                if (tag_empty) err <= 1'b1;
            end
        end
    end

    assign fft_idata_en = in_vld_p1;
    assign fft_idata_r  = in_r_p1;
    assign fft_idata_i  = in_i_p1;
    assign odata_en     = out_vld_p1;
    assign odata_r      = out_r_p1;
    assign odata_i      = out_i_p1;
    assign odata_ch     = out_ch_p1;
    assign odata_sof    = out_sof_p1;
endmodule
